renkon_ctrl_net: RTL and testbench
==================================

Name: renkon_ctrl_net

Overview:
Controller in front of the renkon network (weight) memory. It multiplexes the single memory port between host weight loading and core-side weight fetch bursts. A fetch streams weights base..base+len-1 to the convolution datapath over a valid/ready handshake, and the port's one-cycle registered-address read latency is hidden behind that handshake.

Parameters:
DWIDTH, 16, weight data width; must match the memory.
RENKON_NETSIZE, 11, memory address width; the memory holds 2**RENKON_NETSIZE words.
LWIDTH, RENKON_NETSIZE+1, burst length width, so one burst can cover the full memory.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  reset, synchronous, active-high.
host_we  in  1  host write strobe; accepted only while host_ready=1.
host_addr  in  RENKON_NETSIZE  host write address.
host_wdata  in  DWIDTH signed  host write data.
host_ready  out  1  1 in IDLE; a host write is accepted this cycle.
fetch_req  in  1  level request for a fetch burst.
fetch_base  in  RENKON_NETSIZE  first address of the burst; sampled on fetch_ack.
fetch_len  in  LWIDTH  number of words in the burst; sampled on fetch_ack.
fetch_ack  out  1  one-cycle pulse; burst accepted.
w_valid  out  1  w_data is valid.
w_data  out  DWIDTH signed  weight word.
w_last  out  1  marks the final word of the burst; qualified by w_valid.
w_ready  in  1  consumer accepts the word.
done  out  1  one-cycle pulse after the last word is accepted.
mem_we  out  1  memory write enable.
mem_addr  out  RENKON_NETSIZE  memory address; registered by the memory each clock.
write_data  out  DWIDTH signed  memory write data.
read_data  in  DWIDTH signed  data from the memory; equals mem[mem_addr of the previous cycle].

Behaviour:
- Reset: state=IDLE. host_ready=1 on the first cycle after reset. fetch_ack=0, w_valid=0, w_last=0, done=0, mem_we=0, mem_addr=0, write_data=0. Internal counters are cleared.
- States: IDLE, FETCH, DONE.
- IDLE, host write:
  - If host_we=1, drive mem_we=1, mem_addr=host_addr, write_data=host_wdata combinationally in that cycle.
  - The memory is written at that edge.
  - A host write takes priority over fetch_req in the same cycle. fetch_ack stays 0 and the request is retried next cycle.
- IDLE, fetch start (fetch_req=1, host_we=0):
  - Pulse fetch_ack and latch base/len.
  - len=0: go to DONE. No w_valid is produced.
  - len>0: go to FETCH. mem_addr=fetch_base in that cycle, so the first word is issued.
- FETCH:
  - host_ready=0 and mem_we=0. A host_we in FETCH or DONE is ignored; nothing is written.
  - Let `adv = !w_valid || w_ready`.
  - If adv and words remain to issue: drive mem_addr = next issue address and increment the issue counter.
  - Otherwise drive mem_addr = address of the currently presented word, so read_data stays stable under a stall.
  - w_valid is a register, set the cycle after an issue. It is cleared on acceptance when nothing was issued.
  - w_data = read_data, passed combinationally.
  - Throughput is 1 word/cycle when w_ready stays high. First w_valid appears 1 cycle after fetch_ack.
- Addresses increment modulo 2**RENKON_NETSIZE; wrap-around is legal (e.g. base 2046, len 4 → 2046, 2047, 0, 1).
- w_last=1 with the word whose index is len-1.
- Acceptance of the last word (w_valid & w_ready & w_last) moves the block to DONE.
- DONE: done=1 for one cycle, then IDLE. host_ready returns to 1 the cycle after done.
- fetch_req held high after DONE starts a new burst. Back-to-back bursts have 2 idle cycles between them: DONE plus the IDLE ack cycle.
- Reset in any state aborts immediately. There is no done pulse, and any w_valid is dropped.
- Combinational path w_ready→mem_addr is intended. The consumer must not derive w_ready combinationally from mem_addr.

Decomposition:
- Shared package/header (renkon.vh / ninjin.vh): DWIDTH, RENKON_NETSIZE, and state encodings RNET_IDLE, RNET_FETCH, RNET_DONE.
- One natural sub-module: renkon_ctrl_net_seq. It holds the issue/accept counters, the address generator and the w_valid/w_last logic.
- The top level holds the FSM and the host/fetch mux onto the memory port.
- The bench instantiates the real renkon network memory as the downstream.

Test Plan:
- Host load: write mem[k] = k*3-100 for k=0..15 while idle → host_ready=1 throughout, mem_we pulses 16 times, no fetch_ack.
- Fetch base=4, len=5, w_ready=1 → fetch_ack pulse; w_data = -88, -85, -82, -79, -76 on 5 consecutive cycles; w_last on -76; done 1 cycle later.
- Same fetch with w_ready toggling 1,0,0,1,... → the same 5 values in order; w_data is unchanged during stall cycles; no word is duplicated or dropped.
- Wrap: preload 2046→7, 2047→8, 0→9, 1→10; fetch base=2046, len=4 → 7, 8, 9, 10, with w_last on 10.
- len=0 → fetch_ack then done the next cycle, w_valid never asserted. A host_we simultaneous with fetch_req wins, and ack follows one cycle later.
- rst=1 after the 2nd word of a len=8 burst → the next cycle shows w_valid=0, host_ready=1 and no done. A following host write to addr 5 succeeds.

Source files
------------

// File: rtl/renkon_ctrl_net_pkg.sv
// Shared definitions for the renkon network-memory controller:
// default widths and the controller state encoding.
package renkon_ctrl_net_pkg;

    localparam int RNET_DWIDTH  = 16;
    localparam int RNET_NETSIZE = 11;
    localparam int RNET_LWIDTH  = RNET_NETSIZE + 1;

    typedef enum logic [1:0] {
        RNET_IDLE  = 2'd0,
        RNET_FETCH = 2'd1,
        RNET_DONE  = 2'd2
    } rnet_state_e;

endpackage

// File: rtl/renkon_ctrl_net_seq.sv
// Burst sequencer: issue/accept counters, memory address generation and
// the w_valid/w_last output stage. One word is in flight at most, so the
// memory's one-cycle read latency lines up with the valid register.
module renkon_ctrl_net_seq
    import renkon_ctrl_net_pkg::*;
#(
    parameter int RENKON_NETSIZE = RNET_NETSIZE,
    parameter int LWIDTH         = RENKON_NETSIZE + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [RENKON_NETSIZE-1:0] base,
    input  logic [LWIDTH-1:0]         len,
    input  logic                      active,
    input  logic                      w_ready,
    output logic [RENKON_NETSIZE-1:0] addr,
    output logic                      w_valid,
    output logic                      w_last,
    output logic                      last_acc
);

    logic [RENKON_NETSIZE-1:0] base_q, base_d;
    logic [LWIDTH-1:0]         len_q, len_d;
    logic [LWIDTH-1:0]         issue_q, issue_d;
    logic [LWIDTH-1:0]         acc_q, acc_d;
    logic                      valid_q, valid_d;
    logic                      adv;
    logic                      accept;

    assign adv      = !valid_q || w_ready;
    assign accept   = valid_q && w_ready;
    assign w_valid  = valid_q;
    assign w_last   = valid_q && (acc_q == (len_q - LWIDTH'(1)));
    assign last_acc = accept && w_last;

    // Next counters/valid and the address to present; a stall re-reads the current word.
    always_comb begin
        base_d  = base_q;
        len_d   = len_q;
        issue_d = issue_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        addr    = base_q + acc_q[RENKON_NETSIZE-1:0];
        if (start) begin
            base_d  = base;
            len_d   = len;
            issue_d = LWIDTH'(1);
            acc_d   = '0;
            valid_d = 1'b1;
            addr    = base;
        end else if (active) begin
            if (accept) begin
                acc_d = acc_q + LWIDTH'(1);
            end
            if (adv && (issue_q < len_q)) begin
                addr    = base_q + issue_q[RENKON_NETSIZE-1:0];
                issue_d = issue_q + LWIDTH'(1);
                valid_d = 1'b1;
            end else if (accept) begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Sequencer registers; reset drops any presented word.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            len_q   <= '0;
            issue_q <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            base_q  <= base_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/renkon_ctrl_net.sv
// Renkon network-memory controller: arbitrates the single memory port
// between host weight loading (IDLE only) and core-side fetch bursts.
module renkon_ctrl_net
    import renkon_ctrl_net_pkg::*;
#(
    parameter int DWIDTH         = RNET_DWIDTH,
    parameter int RENKON_NETSIZE = RNET_NETSIZE,
    parameter int LWIDTH         = RENKON_NETSIZE + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      host_we,
    input  logic [RENKON_NETSIZE-1:0] host_addr,
    input  logic signed [DWIDTH-1:0]  host_wdata,
    output logic                      host_ready,
    input  logic                      fetch_req,
    input  logic [RENKON_NETSIZE-1:0] fetch_base,
    input  logic [LWIDTH-1:0]         fetch_len,
    output logic                      fetch_ack,
    output logic                      w_valid,
    output logic signed [DWIDTH-1:0]  w_data,
    output logic                      w_last,
    input  logic                      w_ready,
    output logic                      done,
    output logic                      mem_we,
    output logic [RENKON_NETSIZE-1:0] mem_addr,
    output logic signed [DWIDTH-1:0]  write_data,
    input  logic signed [DWIDTH-1:0]  read_data
);

    rnet_state_e               state_q, state_d;
    logic                      start;
    logic                      seq_active;
    logic [RENKON_NETSIZE-1:0] seq_addr;
    logic                      last_acc;

    assign seq_active = (state_q == RNET_FETCH);
    assign w_data     = read_data;

    renkon_ctrl_net_seq #(
        .RENKON_NETSIZE(RENKON_NETSIZE),
        .LWIDTH        (LWIDTH)
    ) u_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .base    (fetch_base),
        .len     (fetch_len),
        .active  (seq_active),
        .w_ready (w_ready),
        .addr    (seq_addr),
        .w_valid (w_valid),
        .w_last  (w_last),
        .last_acc(last_acc)
    );

    // Next state plus the memory-port mux; host writes beat a same-cycle fetch request.
    always_comb begin
        state_d    = state_q;
        host_ready = 1'b0;
        fetch_ack  = 1'b0;
        done       = 1'b0;
        start      = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        write_data = '0;
        case (state_q)
            RNET_IDLE: begin
                host_ready = 1'b1;
                if (host_we) begin
                    mem_we     = 1'b1;
                    mem_addr   = host_addr;
                    write_data = host_wdata;
                end else if (fetch_req) begin
                    fetch_ack = 1'b1;
                    mem_addr  = fetch_base;
                    if (fetch_len == '0) begin
                        state_d = RNET_DONE;
                    end else begin
                        start   = 1'b1;
                        state_d = RNET_FETCH;
                    end
                end
            end
            RNET_FETCH: begin
                mem_addr = seq_addr;
                if (last_acc) begin
                    state_d = RNET_DONE;
                end
            end
            RNET_DONE: begin
                done    = 1'b1;
                state_d = RNET_IDLE;
            end
            default: begin
                state_d = RNET_IDLE;
            end
        endcase
    end

    // State register; reset aborts any burst without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RNET_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_renkon_ctrl_net.sv
// Bench for renkon_ctrl_net: a registered-read network memory downstream,
// a shadow-memory word model with a per-cycle compare process, and
// directed scenarios with literal expectations.
module tb_renkon_ctrl_net;
    import renkon_ctrl_net_pkg::*;

    localparam int DW    = RNET_DWIDTH;
    localparam int NS    = RNET_NETSIZE;
    localparam int LW    = RNET_LWIDTH;
    localparam int DEPTH = 2 ** NS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 host_we;
    logic [NS-1:0]        host_addr;
    logic signed [DW-1:0] host_wdata;
    logic                 host_ready;
    logic                 fetch_req;
    logic [NS-1:0]        fetch_base;
    logic [LW-1:0]        fetch_len;
    logic                 fetch_ack;
    logic                 w_valid;
    logic signed [DW-1:0] w_data;
    logic                 w_last;
    logic                 w_ready;
    logic                 done;
    logic                 mem_we;
    logic [NS-1:0]        mem_addr;
    logic signed [DW-1:0] write_data;
    logic signed [DW-1:0] read_data;

    renkon_ctrl_net dut (
        .clk       (clk),
        .rst       (rst),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_ready(host_ready),
        .fetch_req (fetch_req),
        .fetch_base(fetch_base),
        .fetch_len (fetch_len),
        .fetch_ack (fetch_ack),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_last    (w_last),
        .w_ready   (w_ready),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .write_data(write_data),
        .read_data (read_data)
    );

    // Network memory: registered address, one-cycle read latency.
    logic signed [DW-1:0] mem [0:DEPTH-1];
    logic signed [DW-1:0] rd_q;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= write_data;
        rd_q <= mem[mem_addr];
    end
    assign read_data = rd_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int d;
        bit last;
    } exp_t;
    exp_t exp_q[$];
    int   shadow [0:DEPTH-1];
    int   got_d[$];
    bit   got_l[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle compare against the shadow-memory word model.
    bit prev_stall = 1'b0;
    int prev_data  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (w_valid) chk("host_ready while word presented", int'(host_ready), 0);
            if (!host_ready) chk("mem_we while busy", int'(mem_we), 0);
            if (prev_stall && w_valid) chk("w_data held under stall", int'(w_data), prev_data);
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected word: got %0d expected none", w_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("w_data", int'(w_data), e.d);
                    chk("w_last", int'(w_last), int'(e.last));
                end
            end
            prev_stall = w_valid && !w_ready;
            prev_data  = int'(w_data);
        end
    end

    task automatic host_write(input int addr, input int data);
        @(posedge clk); #1;
        host_we    = 1'b1;
        host_addr  = NS'(addr);
        host_wdata = DW'(data);
        fetch_req  = 1'b0;
        @(negedge clk);
        chk("host write mem_we", int'(mem_we), 1);
        chk("host write addr", int'(mem_addr), addr);
        chk("host write host_ready", int'(host_ready), 1);
        chk("host write no ack", int'(fetch_ack), 0);
        shadow[addr] = data;
    endtask

    task automatic host_idle();
        @(posedge clk); #1;
        host_we = 1'b0;
    endtask

    // mode 0: w_ready always 1; mode 1: w_ready pattern 1,0,0 repeating.
    task automatic run_fetch(input int base, input int len, input int mode, input bit junk);
        int  cyc;
        int  done_cyc;
        int  valid_cnt;
        int  extra_ack;
        bit  seen_done;
        got_d.delete();
        got_l.delete();
        @(posedge clk); #1;
        host_we    = 1'b0;
        fetch_req  = 1'b1;
        fetch_base = NS'(base);
        fetch_len  = LW'(len);
        w_ready    = (mode == 0);
        for (int i = 0; i < len; i++)
            exp_q.push_back('{shadow[(base + i) % DEPTH], (i == len - 1)});
        @(negedge clk);
        chk("fetch_ack", int'(fetch_ack), 1);
        if (len > 0) chk("first issue addr", int'(mem_addr), base);
        seen_done = 1'b0;
        cyc       = 0;
        done_cyc  = -1;
        valid_cnt = 0;
        extra_ack = 0;
        while (!seen_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            fetch_req = 1'b0;
            w_ready   = (mode == 0) ? 1'b1 : ((cyc - 1) % 3 == 0);
            if (junk) begin
                host_we    = 1'b1;
                host_addr  = NS'(6);
                host_wdata = DW'(999);
            end
            @(negedge clk);
            if (cyc == 1) chk("w_valid one cycle after ack", int'(w_valid), int'(len > 0));
            if (fetch_ack) extra_ack++;
            if (w_valid) valid_cnt++;
            if (w_valid && w_ready) begin
                got_d.push_back(int'(w_data));
                got_l.push_back(w_last);
            end
            if (done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end
        end
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL fetch timeout: got no done expected done within 200 cycles");
        end
        chk("words accepted", got_d.size(), len);
        chk("model queue drained", exp_q.size(), 0);
        chk("no extra fetch_ack", extra_ack, 0);
        if (mode == 0) begin
            chk("done cycle after ack", done_cyc, len + 1);
            chk("w_valid cycles", valid_cnt, len);
        end
        @(posedge clk); #1;
        host_we = 1'b0;
        w_ready = 1'b0;
        @(negedge clk);
        chk("done is one pulse", int'(done), 0);
        chk("host_ready after done", int'(host_ready), 1);
    endtask

    int lit_a [0:4] = '{-88, -85, -82, -79, -76};
    int lit_w [0:3] = '{7, 8, 9, 10};

    initial begin
        int we_cnt;
        rst        = 1'b1;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        fetch_req  = 1'b0;
        fetch_base = '0;
        fetch_len  = '0;
        w_ready    = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset host_ready", int'(host_ready), 1);
        chk("reset fetch_ack", int'(fetch_ack), 0);
        chk("reset w_valid", int'(w_valid), 0);
        chk("reset w_last", int'(w_last), 0);
        chk("reset done", int'(done), 0);
        chk("reset mem_we", int'(mem_we), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        chk("reset write_data", int'(write_data), 0);

        // Host load mem[k] = 3k - 100.
        we_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            host_write(k, k * 3 - 100);
            if (mem_we) we_cnt++;
        end
        host_idle();
        chk("host load mem_we pulses", we_cnt, 16);

        // Full-rate burst.
        run_fetch(4, 5, 0, 1'b0);
        for (int i = 0; i < 5; i++)
            if (i < got_d.size()) chk("burst literal word", got_d[i], lit_a[i]);
        if (got_l.size() == 5) chk("burst literal last", int'(got_l[4]), 1);

        // Stalled burst with host writes attempted while busy.
        run_fetch(4, 5, 1, 1'b1);
        for (int i = 0; i < 5; i++)
            if (i < got_d.size()) chk("stall literal word", got_d[i], lit_a[i]);
        chk("stall no junk write", int'(mem[6]), -82);

        // Address wrap-around.
        host_write(2046, 7);
        host_write(2047, 8);
        host_write(0, 9);
        host_write(1, 10);
        host_idle();
        run_fetch(2046, 4, 0, 1'b0);
        for (int i = 0; i < 4; i++)
            if (i < got_d.size()) chk("wrap literal word", got_d[i], lit_w[i]);
        if (got_l.size() == 4) chk("wrap literal last", int'(got_l[3]), 1);

        // Host write beats a simultaneous request; then a zero-length burst.
        @(posedge clk); #1;
        host_we    = 1'b1;
        host_addr  = NS'(20);
        host_wdata = DW'(55);
        fetch_req  = 1'b1;
        fetch_base = '0;
        fetch_len  = '0;
        @(negedge clk);
        chk("priority no ack", int'(fetch_ack), 0);
        chk("priority mem_we", int'(mem_we), 1);
        chk("priority addr", int'(mem_addr), 20);
        shadow[20] = 55;
        run_fetch(0, 0, 0, 1'b0);

        // Reset aborts a len=8 burst after its second word.
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_base = '0;
        fetch_len  = LW'(8);
        w_ready    = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back('{shadow[i], (i == 7)});
        @(negedge clk);
        chk("abort ack", int'(fetch_ack), 1);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("abort word0 valid", int'(w_valid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort word1 valid", int'(w_valid), 1);
        @(posedge clk); #1;
        rst     = 1'b1;
        w_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort w_valid", int'(w_valid), 0);
        chk("abort host_ready", int'(host_ready), 1);
        chk("abort no done", int'(done), 0);
        host_write(5, 1234);
        chk("post-abort no done", int'(done), 0);
        host_idle();
        run_fetch(5, 1, 0, 1'b0);
        if (got_d.size() == 1) chk("post-abort readback", got_d[0], 1234);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
